// File: rtl/avs_uart_pkg.sv
// Shared definitions for the event-timestamp UART transmitter: frame layout and TX state encoding.
package avs_uart_pkg;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/event_uart_tx.sv
// Timestamps rising edges of event_in and sends each as an 8N1 frame: SYNC_BYTE, ts[15:8], ts[7:0].
module event_uart_tx
  import avs_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int TS_WIDTH     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        event_in,
  output logic                        uart_out,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(FRAME_BYTES - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           byte_q, byte_d;
  logic [TS_WIDTH-1:0]  shadow_q, shadow_d;
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 ev_prev_q, overflow_q, uart_q, uart_d;
  logic                 ev_rise, fifo_pop, fifo_full, fifo_empty;
  logic [TS_WIDTH-1:0]  fifo_rdata;
  logic [7:0]           tx_byte;

  assign ev_rise  = event_in && !ev_prev_q;
  assign uart_out = uart_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  sync_fifo #(.WIDTH(TS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ev_rise),
    .pop   (fifo_pop),
    .wdata (ts_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    case (byte_q)
      2'd0:    tx_byte = SYNC_BYTE;
      2'd1:    tx_byte = shadow_q[15:8];
      default: tx_byte = shadow_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    fifo_pop = 1'b0;
    uart_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shadow_d = fifo_rdata;
          byte_d   = '0;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        uart_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        uart_d = tx_byte[bit_q];
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      ts_q       <= '0;
      ev_prev_q  <= 1'b0;
      overflow_q <= 1'b0;
      uart_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      ts_q      <= ts_q + 1'b1;
      ev_prev_q <= event_in;
      uart_q    <= uart_d;
      if (ev_rise && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
  end
endmodule

// File: tb/tb_event_uart_tx.sv
// Scoreboard bench for event_uart_tx: stimulus queues expected bytes, a UART receiver pops and compares.
module tb_event_uart_tx;
  localparam int CPB = 4;

  logic       clock, reset, event_in;
  logic       uart_out, busy, overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[$];
  logic [15:0] tb_ts;
  logic        prev_line = 1'b1;
  logic        mon_ok;
  logic [7:0]  mon_b;
  logic [7:0]  mon_exp;

  event_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .TS_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .event_in   (event_in),
    .uart_out   (uart_out),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference timestamp counter: cleared by reset, +1 every clock, wraps at 16 bits.
  always @(posedge clock) tb_ts <= reset ? 16'h0000 : tb_ts + 16'h0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] ts);
    sb.push_back(8'hA5);
    sb.push_back(ts[15:8]);
    sb.push_back(ts[7:0]);
  endtask

  // Called at a negedge; raises event_in so the next posedge samples it with ts == target.
  task automatic pulse_at(input logic [15:0] target, input bit expect_sent);
    int n = 0;
    while (tb_ts != target && n < 70000) begin
      @(negedge clock);
      n++;
    end
    check("ts_wait_timeout", 32'(tb_ts == target), 32'd1);
    event_in = 1'b1;
    if (expect_sent) push_frame(target);
    @(negedge clock);
    event_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // UART receiver: mid-bit sampling, aborts a byte if reset is seen while it is in flight.
  always begin
    @(negedge clock);
    if (!reset && prev_line === 1'b1 && uart_out === 1'b0) begin
      mon_ok = 1'b1;
      repeat (CPB/2) @(negedge clock);
      if (reset) mon_ok = 1'b0;
      else check("start_bit", 32'(uart_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        if (reset) mon_ok = 1'b0;
        mon_b[i] = uart_out;
      end
      repeat (CPB) @(negedge clock);
      if (reset) mon_ok = 1'b0;
      if (mon_ok) begin
        check("stop_bit", 32'(uart_out), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", mon_b, $time);
        end else begin
          mon_exp = sb.pop_front();
          check("frame_byte", 32'(mon_b), 32'(mon_exp));
        end
      end
    end
    prev_line = uart_out;
  end

  initial begin
    logic [2:0]  peak;
    logic [15:0] t5;
    bit          idle_ok;

    // Test 1: reset held with event_in toggling
    reset    = 1'b1;
    event_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      event_in = ~event_in;
    end
    @(negedge clock);
    check("rst_uart", 32'(uart_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    event_in = 1'b0;
    reset    = 1'b0;

    // Test 2: single edge at ts 0x0123, latency and frame length
    pulse_at(16'h0123, 1'b1);
    check("lat_busy_p0", 32'(busy), 32'd0);
    @(negedge clock);
    check("lat_uart_p1", 32'(uart_out), 32'd1);
    check("lat_busy_p1", 32'(busy), 32'd1);
    @(negedge clock);
    check("lat_uart_p2", 32'(uart_out), 32'd0);
    repeat (118) @(negedge clock);
    check("len_busy_p120", 32'(busy), 32'd1);
    @(negedge clock);
    check("len_busy_p121", 32'(busy), 32'd0);
    check("len_uart_p121", 32'(uart_out), 32'd1);
    wait_drain("t2_drain", 50);

    // Test 3: level held high for 500 cycles gives a single record
    repeat (5) @(negedge clock);
    peak = '0;
    event_in = 1'b1;
    push_frame(tb_ts);
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (fifo_count > peak) peak = fifo_count;
    end
    event_in = 1'b0;
    check("hold_peak_le1", 32'(peak <= 3'd1), 32'd1);
    repeat (10) @(negedge clock);
    check("hold_one_frame", 32'(sb.size()), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_count", 32'(fifo_count), 32'd0);

    // Test 4: six edges 3 cycles apart against a 4-deep FIFO
    for (int k = 0; k < 6; k++) begin
      event_in = 1'b1;
      if (k < 5) push_frame(tb_ts);
      @(negedge clock);
      event_in = 1'b0;
      repeat (2) @(negedge clock);
      if (k == 4) check("burst_count_full", 32'(fifo_count), 32'd4);
      if (k == 4) check("burst_ovf_before", 32'(overflow), 32'd0);
    end
    check("burst_count_after", 32'(fifo_count), 32'd4);
    check("burst_ovf", 32'(overflow), 32'd1);
    wait_drain("burst_drain", 1000);
    repeat (10) @(negedge clock);
    check("burst_ovf_sticky", 32'(overflow), 32'd1);
    check("burst_idle", 32'(busy), 32'd0);

    // Test 6: timestamp wrap
    pulse_at(16'hFFFF, 1'b1);
    pulse_at(16'h0005, 1'b1);
    wait_drain("wrap_drain", 600);
    repeat (10) @(negedge clock);

    // Test 5: reset during data bit 3 of the last byte
    t5 = tb_ts + 16'd3;
    pulse_at(t5, 1'b1);
    repeat (98) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_uart", 32'(uart_out), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (uart_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) idle_ok = 1'b0;
    end
    check("abort_quiet", 32'(idle_ok), 32'd1);
    check("abort_lost_byte", 32'(sb.size()), 32'd1);
    sb.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
